rotor_setting_bank: RTL and testbench
=====================================

// Module: rotor_setting_bank
// PURPOSE
//   Parametrised bank of NUM_CH bounded rotor-position registers, replacing the fixed 8-rotor select
//   and per-digit max muxes. Toggle buttons pick one channel, and encoder inc/dec steps then move that
//   channel's value, wrapping at a per-channel maximum. Sits between the button/encoder synchronizers
//   and the cipher/display datapath.
// PARAMETERS
//   NUM_CH      8   number of rotor channels (>=2)
//   VAL_W       8   value width per channel
//   STEP_DELAY  4   cycles from accepted step edge to value update (>=1); also the lockout window
// PORTS
//   clock       in   1               system clock
//   reset       in   1               synchronous, active-high
//   btn_sync    in   NUM_CH          synchronized select buttons, level
//   inc         in   1               synchronized encoder "up" level
//   dec         in   1               synchronized encoder "down" level
//   clear       in   1               synchronous clear of all values
//   max_flat    in   NUM_CH*VAL_W    per-channel max; ch k at [k*VAL_W +: VAL_W]
//   sel_onehot  out  NUM_CH          selected channel, one-hot or zero
//   sel_valid   out  1               |sel_onehot
//   value_flat  out  NUM_CH*VAL_W    current values, same packing as max_flat
//   busy        out  1               step pending (WAIT state)
//   step_done   out  1               1-cycle pulse on the cycle a value is written
//   wrap_pulse  out  1               1-cycle pulse when that write wrapped
// BEHAVIOUR
//   Reset (active-high, synchronous, on clock):
//   - all values, sel_onehot, busy, step_done and wrap_pulse are 0.
//   - both FSMs go to IDLE. Reset mid-WAIT drops the pending step.
//   Press detect:
//   - btn_prev is registered.
//   - press = (btn_prev==0) && btn_sync is exactly one-hot.
//   - multi-bit patterns and held buttons are ignored.
//   Select FSM, SEL_IDLE/SEL_ACTIVE. sel_onehot changes at the edge that samples the press:
//   - SEL_IDLE + press k -> ACTIVE, sel=k.
//   - ACTIVE + press of the selected k -> IDLE, sel=0.
//   - ACTIVE + press j!=k -> ACTIVE, sel=j.
//   Step edge:
//   - inc_rise = inc & ~inc_q; dec_rise likewise.
//   - inc_rise & dec_rise together -> both ignored.
//   Step FSM, STEP_IDLE/STEP_WAIT:
//   - STEP_IDLE: an edge is accepted only if sel_valid. Accepted at edge N: latch the channel index
//     and direction, cnt=STEP_DELAY-1, go to WAIT, busy=1 from N.
//   - STEP_WAIT: cnt decrements. When cnt==0 the value is written at edge N+STEP_DELAY, step_done=1,
//     return to IDLE, busy=0.
//   - Edges arriving during WAIT are dropped; no queueing.
//   - A selection change during WAIT does not redirect the step: the latched channel is used.
//   Arithmetic (unsigned, VAL_W bits, max read at write time):
//   - inc: v>=max -> v=0, wrap_pulse=1; else v+1.
//   - dec: v==0 -> v=max, wrap_pulse=1; v>max -> v=max, no wrap; else v-1.
//   - max==0: the channel stays 0; every inc/dec pulses wrap.
//   clear:
//   - zeros all values and forces the step FSM to IDLE (pending step lost, no step_done).
//   - selection is unchanged.
//   - clear wins over a write in the same cycle.
//   Outputs: all outputs are registered. step_done and wrap_pulse are 0 outside the write cycle.
// TESTING
//   1. Reset, press btn[2] (0->0x04->0) -> sel_onehot=0x04 at the next edge; press btn[2] again -> sel=0.
//   2. Sel ch2, max2=9, v=9, inc pulse -> v2=0 exactly 4 cycles after the edge, wrap_pulse=1, step_done=1.
//   3. Sel ch0, v=0, max0=0x19, dec -> v0=0x19 + wrap. Then set max0=5, v=0x19, dec -> v0=5, no wrap.
//   4. inc edge then two more inc edges within 3 cycles -> exactly one increment; busy high 4 cycles.
//   5. Accept inc on ch1, switch sel to ch3 during WAIT -> ch1 increments, ch3 unchanged.
//   6. Simultaneous inc+dec -> no change. btn 0x06 -> sel unchanged. clear/reset mid-WAIT -> all 0, no step_done.

Source files
------------

// File: rtl/rotor_setting_bank.sv
// Bank of NUM_CH bounded rotor-position registers: toggle buttons pick a channel,
// encoder inc/dec edges then step that channel after a fixed delay, wrapping at its max.
module rotor_setting_bank #(
  parameter int NUM_CH     = 8,
  parameter int VAL_W      = 8,
  parameter int STEP_DELAY = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       btn_sync,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clear,
  input  logic [NUM_CH*VAL_W-1:0] max_flat,
  output logic [NUM_CH-1:0]       sel_onehot,
  output logic                    sel_valid,
  output logic [NUM_CH*VAL_W-1:0] value_flat,
  output logic                    busy,
  output logic                    step_done,
  output logic                    wrap_pulse
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_DELAY - 1);

  typedef enum logic {SEL_IDLE, SEL_ACTIVE} sel_state_t;
  typedef enum logic {STEP_IDLE, STEP_WAIT} step_state_t;

  function automatic logic is_onehot(input logic [NUM_CH-1:0] b);
    return (b != '0) && ((b & (b - NUM_CH'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_CH-1:0] b);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (b[k]) idx = IDX_W'(k);
    return idx;
  endfunction

  // Bounded step; result is {wrapped, new value}. A value above max clamps down on dec.
  function automatic logic [VAL_W:0] step_value(input logic up, input logic [VAL_W-1:0] v,
                                               input logic [VAL_W-1:0] m);
    if (up) begin
      if (v >= m) return {1'b1, {VAL_W{1'b0}}};
      return {1'b0, v + VAL_W'(1)};
    end
    if (v == '0) return {1'b1, m};
    if (v > m)   return {1'b0, m};
    return {1'b0, v - VAL_W'(1)};
  endfunction

  sel_state_t          sel_state_q, sel_state_d;
  step_state_t         step_state_q, step_state_d;
  logic [NUM_CH-1:0]   sel_q, sel_d;
  logic                sel_valid_q, sel_valid_d;
  logic [NUM_CH-1:0]   btn_prev_q, btn_prev_d;
  logic                inc_q, inc_d, dec_q, dec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    ch_q, ch_d;
  logic                up_q, up_d;
  logic                step_done_q, step_done_d;
  logic                wrap_q, wrap_d;
  logic [VAL_W-1:0]    value_q [NUM_CH];
  logic [VAL_W-1:0]    value_d [NUM_CH];
  logic [VAL_W-1:0]    max_arr [NUM_CH];
  logic                press, inc_rise, dec_rise;
  logic [VAL_W:0]      stepped;

  for (genvar gk = 0; gk < NUM_CH; gk++) begin : g_pack
    assign max_arr[gk]                      = max_flat[gk*VAL_W +: VAL_W];
    assign value_flat[gk*VAL_W +: VAL_W]    = value_q[gk];
  end

  always_comb begin
    sel_state_d  = sel_state_q;
    sel_d        = sel_q;
    step_state_d = step_state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    up_d         = up_q;
    value_d      = value_q;
    step_done_d  = 1'b0;
    wrap_d       = 1'b0;
    btn_prev_d   = btn_sync;
    inc_d        = inc;
    dec_d        = dec;
    press        = (btn_prev_q == '0) && is_onehot(btn_sync);
    inc_rise     = inc & ~inc_q;
    dec_rise     = dec & ~dec_q;
    stepped      = step_value(up_q, value_q[ch_q], max_arr[ch_q]);

    case (sel_state_q)
      SEL_IDLE: begin
        if (press) begin
          sel_state_d = SEL_ACTIVE;
          sel_d       = btn_sync;
        end
      end
      SEL_ACTIVE: begin
        if (press && (btn_sync == sel_q)) begin
          sel_state_d = SEL_IDLE;
          sel_d       = '0;
        end else if (press) begin
          sel_d = btn_sync;
        end
      end
      default: sel_state_d = SEL_IDLE;
    endcase
    sel_valid_d = |sel_d;

    // Channel and direction are latched at acceptance; later selection changes do not redirect.
    case (step_state_q)
      STEP_IDLE: begin
        if ((inc_rise ^ dec_rise) && sel_valid_q) begin
          step_state_d = STEP_WAIT;
          cnt_d        = CNT_LOAD;
          ch_d         = onehot_idx(sel_q);
          up_d         = inc_rise;
        end
      end
      STEP_WAIT: begin
        if (cnt_q == '0) begin
          value_d[ch_q] = stepped[VAL_W-1:0];
          wrap_d        = stepped[VAL_W];
          step_done_d   = 1'b1;
          step_state_d  = STEP_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: step_state_d = STEP_IDLE;
    endcase

    if (clear) begin
      for (int k = 0; k < NUM_CH; k++) value_d[k] = '0;
      step_state_d = STEP_IDLE;
      step_done_d  = 1'b0;
      wrap_d       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_state_q  <= SEL_IDLE;
      step_state_q <= STEP_IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      btn_prev_q   <= '0;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      step_done_q  <= 1'b0;
      wrap_q       <= 1'b0;
      value_q      <= '{default: '0};
    end else begin
      sel_state_q  <= sel_state_d;
      step_state_q <= step_state_d;
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      btn_prev_q   <= btn_prev_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      step_done_q  <= step_done_d;
      wrap_q       <= wrap_d;
      value_q      <= value_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      up_q         <= up_d;
    end
  end

  assign sel_onehot = sel_q;
  assign sel_valid  = sel_valid_q;
  assign busy       = (step_state_q == STEP_WAIT);
  assign step_done  = step_done_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_rotor_setting_bank.sv
// Bench for rotor_setting_bank: hand-derived vector table, directed corner sequences,
// and randomized traffic against an abstract per-channel model.
module tb_rotor_setting_bank;
  localparam int NUM_CH = 8;
  localparam int VAL_W = 8;
  localparam int STEP_DELAY = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] btn_sync = '0;
  logic inc = 1'b0, dec = 1'b0, clear = 1'b0;
  logic [NUM_CH*VAL_W-1:0] max_flat = '0;
  logic [NUM_CH-1:0] sel_onehot;
  logic sel_valid, busy, step_done, wrap_pulse;
  logic [NUM_CH*VAL_W-1:0] value_flat;

  rotor_setting_bank #(.NUM_CH(NUM_CH), .VAL_W(VAL_W), .STEP_DELAY(STEP_DELAY)) dut (
    .clock(clock), .reset(reset), .btn_sync(btn_sync), .inc(inc), .dec(dec), .clear(clear),
    .max_flat(max_flat), .sel_onehot(sel_onehot), .sel_valid(sel_valid), .value_flat(value_flat),
    .busy(busy), .step_done(step_done), .wrap_pulse(wrap_pulse)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Abstract model: selected index (-1 none), plain value array, pending step with cycles left.
  int m_sel;
  int m_val [NUM_CH];
  int m_pch, m_left;
  bit m_pup, m_done, m_wrap;
  logic [NUM_CH-1:0] m_pbtn;
  bit m_pinc, m_pdec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int old_sel, v, mx;
    bit ir, dr;
    if (reset) begin
      m_sel = -1; m_left = 0; m_done = 0; m_wrap = 0; m_pbtn = '0; m_pinc = 0; m_pdec = 0;
      foreach (m_val[k]) m_val[k] = 0;
      return;
    end
    old_sel = m_sel;
    m_done = 0;
    m_wrap = 0;
    if (m_pbtn == '0 && $countones(btn_sync) == 1)
      for (int k = 0; k < NUM_CH; k++)
        if (btn_sync[k]) m_sel = (m_sel == k) ? -1 : k;
    ir = inc && !m_pinc;
    dr = dec && !m_pdec;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        v = m_val[m_pch];
        mx = int'(max_flat[m_pch*VAL_W +: VAL_W]);
        if (m_pup) begin
          if (v >= mx) begin v = 0; m_wrap = 1; end
          else v = v + 1;
        end else begin
          if (v == 0) begin v = mx; m_wrap = 1; end
          else if (v > mx) v = mx;
          else v = v - 1;
        end
        m_val[m_pch] = v;
        m_done = 1;
      end
    end else if ((ir ^ dr) && old_sel >= 0) begin
      m_pch = old_sel; m_pup = ir; m_left = STEP_DELAY;
    end
    if (clear) begin
      foreach (m_val[k]) m_val[k] = 0;
      m_left = 0; m_done = 0; m_wrap = 0;
    end
    m_pbtn = btn_sync; m_pinc = inc; m_pdec = dec;
  endtask

  task automatic check_all();
    logic [NUM_CH*VAL_W-1:0] ev;
    for (int k = 0; k < NUM_CH; k++) ev[k*VAL_W +: VAL_W] = VAL_W'(m_val[k]);
    chk("sel_onehot", sel_onehot, (m_sel < 0) ? 64'd0 : (64'd1 << m_sel));
    chk("sel_valid", sel_valid, m_sel >= 0);
    chk("busy", busy, m_left > 0);
    chk("step_done", step_done, m_done);
    chk("wrap_pulse", wrap_pulse, m_wrap);
    chk("value_flat", value_flat, ev);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic reset_dut();
    reset = 1'b1; btn_sync = '0; inc = 0; dec = 0; clear = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic press(input logic [NUM_CH-1:0] b);
    btn_sync = b; tick();
    btn_sync = '0; tick();
  endtask

  task automatic run_until_done(output bit got, output int cyc);
    got = 0; cyc = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      cyc++;
      if (step_done) got = 1;
    end
  endtask

  typedef struct {
    logic [7:0] btn; bit i; bit d;
    logic [7:0] sel; bit bsy; bit dn; bit wr; logic [7:0] v2;
  } vec_t;
  vec_t tv[$];

  function automatic void add(logic [7:0] b, bit i, bit d, logic [7:0] s, bit bz, bit dn,
                              bit wr, logic [7:0] v);
    vec_t r;
    r.btn = b; r.i = i; r.d = d; r.sel = s; r.bsy = bz; r.dn = dn; r.wr = wr; r.v2 = v;
    tv.push_back(r);
  endfunction

  initial begin
    bit got;
    int cyc, busy_cnt, done_cnt;
    bit pat [8] = '{1, 0, 1, 0, 1, 0, 0, 0};

    // Reset state
    reset_dut();
    tick();
    chk("rst_sel", sel_onehot, 0);
    chk("rst_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vals", value_flat, 0);
    chk("rst_done", step_done, 0);

    // Vector table: ch2 with max 9; dec from 0 wraps to 9, inc from 9 wraps to 0
    max_flat = '0;
    max_flat[2*VAL_W +: VAL_W] = 8'd9;
    add(8'h04, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h00, 0, 1, 8'h04, 1, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 0, 1, 1, 9);
    add(8'h00, 0, 0, 8'h04, 0, 0, 0, 9);
    add(8'h00, 1, 0, 8'h04, 1, 0, 0, 9);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 9);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 9);
    add(8'h00, 0, 0, 8'h04, 1, 0, 0, 9);
    add(8'h00, 0, 0, 8'h04, 0, 1, 1, 0);
    add(8'h04, 0, 0, 8'h00, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    add(8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    add(8'h04, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h06, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h00, 1, 1, 8'h04, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h04, 0, 0, 0, 0);
    add(8'h20, 0, 0, 8'h20, 0, 0, 0, 0);
    add(8'h00, 0, 0, 8'h20, 0, 0, 0, 0);
    reset_dut();
    for (int r = 0; r < tv.size(); r++) begin
      btn_sync = tv[r].btn; inc = tv[r].i; dec = tv[r].d;
      tick();
      chk($sformatf("tv%0d_sel", r), sel_onehot, tv[r].sel);
      chk($sformatf("tv%0d_busy", r), busy, tv[r].bsy);
      chk($sformatf("tv%0d_done", r), step_done, tv[r].dn);
      chk($sformatf("tv%0d_wrap", r), wrap_pulse, tv[r].wr);
      chk($sformatf("tv%0d_v2", r), value_flat[2*VAL_W +: VAL_W], tv[r].v2);
    end
    btn_sync = '0; inc = 0; dec = 0;

    // dec at 0 wraps to max; dec above max clamps without wrap
    reset_dut();
    max_flat[0 +: VAL_W] = 8'h19;
    press(8'h01);
    dec = 1; tick(); dec = 0;
    run_until_done(got, cyc);
    chk("t3_got", got, 1);
    chk("t3_cyc", cyc, STEP_DELAY);
    chk("t3_v0", value_flat[0 +: VAL_W], 8'h19);
    chk("t3_wrap", wrap_pulse, 1);
    max_flat[0 +: VAL_W] = 8'h05;
    dec = 1; tick(); dec = 0;
    run_until_done(got, cyc);
    chk("t3b_got", got, 1);
    chk("t3b_v0", value_flat[0 +: VAL_W], 8'h05);
    chk("t3b_wrap", wrap_pulse, 0);

    // Edges during the lockout are dropped
    reset_dut();
    max_flat[0 +: VAL_W] = 8'h19;
    press(8'h01);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      inc = pat[i];
      tick();
      busy_cnt += busy;
      done_cnt += step_done;
    end
    chk("t4_busy_cycles", busy_cnt, STEP_DELAY);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_v0", value_flat[0 +: VAL_W], 1);

    // Selection change during WAIT keeps the latched channel
    max_flat[1*VAL_W +: VAL_W] = 8'd9;
    max_flat[3*VAL_W +: VAL_W] = 8'd9;
    press(8'h02);
    inc = 1; tick(); inc = 0; tick();
    btn_sync = 8'h08; tick(); btn_sync = '0; tick();
    run_until_done(got, cyc);
    chk("t5_got", got, 1);
    chk("t5_v1", value_flat[1*VAL_W +: VAL_W], 1);
    chk("t5_v3", value_flat[3*VAL_W +: VAL_W], 0);
    chk("t5_sel", sel_onehot, 8'h08);

    // clear mid-WAIT
    inc = 1; tick(); inc = 0;
    run_until_done(got, cyc);
    chk("t6_v3_pre", value_flat[3*VAL_W +: VAL_W], 1);
    inc = 1; tick(); inc = 0; tick();
    clear = 1; tick(); clear = 0;
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_vals", value_flat, 0);
    chk("t6_clr_sel", sel_onehot, 8'h08);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); done_cnt += step_done; end
    chk("t6_clr_nodone", done_cnt, 0);

    // reset mid-WAIT
    inc = 1; tick(); inc = 0; tick();
    reset = 1; tick(); reset = 0;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sel", sel_onehot, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); done_cnt += step_done; end
    chk("t6_rst_nodone", done_cnt, 0);
    chk("t6_rst_vals", value_flat, 0);

    // max == 0: value pinned at 0, every step wraps
    max_flat[4*VAL_W +: VAL_W] = 8'd0;
    press(8'h10);
    inc = 1; tick(); inc = 0;
    run_until_done(got, cyc);
    chk("t7_inc_wrap", {got, wrap_pulse}, 2'b11);
    chk("t7_inc_v4", value_flat[4*VAL_W +: VAL_W], 0);
    dec = 1; tick(); dec = 0;
    run_until_done(got, cyc);
    chk("t7_dec_wrap", {got, wrap_pulse}, 2'b11);
    chk("t7_dec_v4", value_flat[4*VAL_W +: VAL_W], 0);

    // Randomized traffic against the model
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      int r;
      if (c % 60 == 0)
        for (int k = 0; k < NUM_CH; k++)
          max_flat[k*VAL_W +: VAL_W] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      r = $urandom_range(0, 99);
      if (r < 70) btn_sync = '0;
      else if (r < 90) btn_sync = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
      else btn_sync = NUM_CH'($urandom);
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
      check_all();
    end
    reset = 0; clear = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
